// File: rtl/udm_pkg.sv
// Shared definitions for the UDM serial link blocks.
package udm_pkg;

    // Parity selection for the UART transmitter.
    localparam int unsigned UDM_PAR_NONE = 0;
    localparam int unsigned UDM_PAR_ODD  = 1;
    localparam int unsigned UDM_PAR_EVEN = 2;

    // Transmit FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop
    } tx_state_e;

    // Width of an occupancy counter that must also hold the value "depth".
    function automatic int unsigned udm_level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/udm_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level. Pushes while full are rejected.
module udm_sync_fifo
    import udm_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = udm_level_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i & ~empty_q;

    // Next occupancy; a simultaneous push and pop cancel out.
    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + LW'(1);
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - LW'(1);
        end
    end

    // Pointers and registered status flags; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            full_q  <= (level_d == LW'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    // Storage array; needs no reset because empty_o guards every read.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign level_o   = level_q;

endmodule

// File: rtl/udm_uart_tx_buf.sv
// Buffered UART transmitter for the UDM debug link: write FIFO in front of a framing FSM
// whose bit period is latched from the auto-baud receiver at each frame start.
module udm_uart_tx_buf
    import udm_pkg::*;
#(
    parameter  int unsigned DATA_BITS  = 8,
    parameter  int unsigned FIFO_DEPTH = 16,
    parameter  int unsigned PARITY     = UDM_PAR_NONE,
    parameter  int unsigned STOP_BITS  = 1,
    parameter  int unsigned BP_WIDTH   = 29,
    localparam int unsigned LVL_W      = udm_level_width(FIFO_DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en_i,
    input  logic [DATA_BITS-1:0] wr_data_bi,
    input  logic                 locked_i,
    input  logic [BP_WIDTH-1:0]  bitperiod_bi,
    input  logic                 ovf_clr_i,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic [LVL_W-1:0]     level_o,
    output logic                 tx_done_tick_o,
    output logic                 ovf_o
);

    localparam bit       HAS_PAR   = (PARITY != UDM_PAR_NONE);
    localparam bit       ODD_PAR   = (PARITY == UDM_PAR_ODD);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    tx_state_e            state_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 par_q;
    logic [BP_WIDTH-1:0]  bp_q;
    logic [BP_WIDTH-1:0]  clk_cnt_q;
    logic [3:0]           bit_cnt_q;
    logic                 tx_q, busy_q, ovf_q;

    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 fifo_full, fifo_empty;
    logic [LVL_W-1:0]     fifo_level;

    logic                 bit_end, last_stop, start_ok, pop;
    logic                 par_bit;
    logic [BP_WIDTH-1:0]  bp_sel;

    udm_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (wr_en_i),
        .wr_data_i (wr_data_bi),
        .pop_i     (pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    // Frame sequencing decode: end of the current bit, end of the frame, next-frame start.
    always_comb begin
        bit_end   = (clk_cnt_q == bp_q - BP_WIDTH'(1));
        last_stop = (state_q == StStop) && (bit_cnt_q == LAST_STOP) && bit_end;
        start_ok  = !fifo_empty && locked_i;
        pop       = start_ok && ((state_q == StIdle) || last_stop);
        par_bit   = (^fifo_rd_data) ^ ODD_PAR;
        // A zero bit period would never end a bit; clamp it to one clock.
        bp_sel    = (bitperiod_bi == '0) ? BP_WIDTH'(1) : bitperiod_bi;
    end

    // Framing FSM with bit and clock counters; tx/busy are registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            bp_q      <= '0;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else if (pop) begin
            // Load next word from IDLE or straight out of the last stop bit (no gap).
            state_q   <= StStart;
            shreg_q   <= fifo_rd_data;
            par_q     <= par_bit;
            bp_q      <= bp_sel;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
                StStart: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        tx_q      <= shreg_q[0];
                        state_q   <= StData;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + BP_WIDTH'(1);
                    end
                end
                StData: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_q <= '0;
                            if (HAS_PAR) begin
                                tx_q    <= par_q;
                                state_q <= StPar;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= StStop;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            tx_q      <= shreg_q[1];
                            shreg_q   <= shreg_q >> 1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + BP_WIDTH'(1);
                    end
                end
                StPar: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        tx_q      <= 1'b1;
                        state_q   <= StStop;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + BP_WIDTH'(1);
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        if (bit_cnt_q == LAST_STOP) begin
                            // Nothing to send (or link unlocked): go idle.
                            bit_cnt_q <= '0;
                            busy_q    <= 1'b0;
                            state_q   <= StIdle;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + BP_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flag; a dropped push beats a clear in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (wr_en_i && fifo_full) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_q <= 1'b0;
        end
    end

    assign tx_o           = tx_q;
    assign busy_o         = busy_q;
    assign empty_o        = fifo_empty;
    assign full_o         = fifo_full;
    assign level_o        = fifo_level;
    assign tx_done_tick_o = last_stop;
    assign ovf_o          = ovf_q;

endmodule

// File: tb/tb_udm_uart_tx_buf.sv
// Self-checking bench: 8N1/depth-4 instance driven through a scoreboard and line monitor,
// plus an 8E2 instance checked bit-by-bit.
module tb_udm_uart_tx_buf;
    import udm_pkg::*;

    localparam int unsigned A_LW = 3;  // depth 4
    localparam int unsigned B_LW = 5;  // depth 16

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic            a_wr_en, a_locked, a_ovf_clr;
    logic [7:0]      a_wr_data;
    logic [28:0]     a_bp;
    logic            a_tx, a_busy, a_empty, a_full, a_done, a_ovf;
    logic [A_LW-1:0] a_level;

    logic            b_wr_en, b_locked, b_ovf_clr;
    logic [7:0]      b_wr_data;
    logic [28:0]     b_bp;
    logic            b_tx, b_busy, b_empty, b_full, b_done, b_ovf;
    logic [B_LW-1:0] b_level;

    udm_uart_tx_buf #(
        .DATA_BITS (8), .FIFO_DEPTH (4), .PARITY (0), .STOP_BITS (1), .BP_WIDTH (29)
    ) dut_a (
        .clk_i (clk), .rst_ni (rst_n), .wr_en_i (a_wr_en), .wr_data_bi (a_wr_data),
        .locked_i (a_locked), .bitperiod_bi (a_bp), .ovf_clr_i (a_ovf_clr),
        .tx_o (a_tx), .busy_o (a_busy), .empty_o (a_empty), .full_o (a_full),
        .level_o (a_level), .tx_done_tick_o (a_done), .ovf_o (a_ovf)
    );

    udm_uart_tx_buf #(
        .DATA_BITS (8), .FIFO_DEPTH (16), .PARITY (2), .STOP_BITS (2), .BP_WIDTH (29)
    ) dut_b (
        .clk_i (clk), .rst_ni (rst_n), .wr_en_i (b_wr_en), .wr_data_bi (b_wr_data),
        .locked_i (b_locked), .bitperiod_bi (b_bp), .ovf_clr_i (b_ovf_clr),
        .tx_o (b_tx), .busy_o (b_busy), .empty_o (b_empty), .full_o (b_full),
        .level_o (b_level), .tx_done_tick_o (b_done), .ovf_o (b_ovf)
    );

    typedef struct {
        logic [7:0] data;
        int         bp;
    } exp_t;

    exp_t sb_a[$];
    int   n_checks   = 0;
    int   n_mismatch = 0;
    bit   mon_en;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected line level per bit slot: start, LSB-first data, optional parity, stops.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input int par);
        logic [15:0] f;
        f    = 16'hFFFF;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        if (par != 0) f[9] = (^d) ^ (par == 1);
        return f;
    endfunction

    // Line monitor for instance A: each observed frame is checked against the scoreboard head.
    initial begin : mon_a
        exp_t        e;
        logic [15:0] fb;
        logic [7:0]  got;
        int          dev, dpos, dcnt, len;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && !a_tx) begin
                check_eq("frame_expected", 32'(sb_a.size() != 0), 32'd1);
                if (sb_a.size() != 0) begin
                    e    = sb_a.pop_front();
                    fb   = frame_bits(e.data, 0);
                    len  = 10 * e.bp;
                    dev  = 0;
                    dpos = -1;
                    dcnt = 0;
                    got  = '0;
                    for (int c = 0; c < len; c++) begin
                        if (c != 0) @(negedge clk);
                        if (a_tx !== fb[c / e.bp]) dev++;
                        if ((c % e.bp) == e.bp / 2 && c / e.bp >= 1 && c / e.bp <= 8)
                            got[c / e.bp - 1] = a_tx;
                        if (a_done) begin
                            dcnt++;
                            dpos = c;
                        end
                    end
                    check_eq("frame_data", got, e.data);
                    check_eq("frame_shape_dev", dev, 0);
                    check_eq("done_count", dcnt, 1);
                    check_eq("done_pos", dpos, len - 1);
                end else begin
                    for (int k = 0; k < 1000 && !a_tx; k++) @(negedge clk);
                end
            end
        end
    end

    task automatic push_a(input logic [7:0] d, input bit expect_sent, input int bp);
        exp_t e;
        a_wr_en   = 1'b1;
        a_wr_data = d;
        if (expect_sent) begin
            e.data = d;
            e.bp   = bp;
            sb_a.push_back(e);
        end
        @(negedge clk);
        a_wr_en = 1'b0;
    endtask

    task automatic wait_busy(input logic val, input int bound, input string tag);
        for (int i = 0; i < bound; i++) begin
            if (a_busy === val) break;
            @(negedge clk);
        end
        check_eq(tag, a_busy, val);
    endtask

    initial begin : main
        logic [7:0]  b_tab [2];
        logic [15:0] fb;
        int          dev, dpos, cnt;

        rst_n = 1'b0;
        a_wr_en = 0; a_wr_data = '0; a_locked = 1; a_bp = 29'd4; a_ovf_clr = 0;
        b_wr_en = 0; b_wr_data = '0; b_locked = 1; b_bp = 29'd3; b_ovf_clr = 0;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        check_eq("rst_tx", a_tx, 1);
        check_eq("rst_busy", a_busy, 0);
        check_eq("rst_empty", a_empty, 1);
        check_eq("rst_full", a_full, 0);
        check_eq("rst_level", a_level, 0);
        check_eq("rst_done", a_done, 0);
        check_eq("rst_ovf", a_ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 8E2 frames at 3 clocks/bit: 36-clock frames with parity and two stop bits
        b_tab[0] = 8'h07;
        b_tab[1] = 8'h03;
        for (int t = 0; t < 2; t++) begin
            b_wr_en   = 1'b1;
            b_wr_data = b_tab[t];
            @(negedge clk);
            b_wr_en = 1'b0;
            for (int k = 0; k < 20 && b_tx; k++) @(negedge clk);
            check_eq("b_start", b_tx, 0);
            fb   = frame_bits(b_tab[t], 2);
            dev  = 0;
            dpos = -1;
            for (int c = 0; c < 36; c++) begin
                if (c != 0) @(negedge clk);
                if (b_tx !== fb[c / 3]) dev++;
                if (b_done) dpos = c;
            end
            check_eq("b_frame_dev", dev, 0);
            check_eq("b_done_pos", dpos, 35);
            @(negedge clk);
            check_eq("b_idle_after", b_busy, 0);
        end

        // 8N1, 4 clocks/bit: start bit two cycles after the write is driven
        push_a(8'hA5, 1, 4);
        check_eq("lat_tx_still_high", a_tx, 1);
        check_eq("lat_level", a_level, 1);
        @(negedge clk);
        check_eq("lat_start", a_tx, 0);
        check_eq("lat_busy", a_busy, 1);
        wait_busy(0, 100, "idle_after_a5");

        // Fill while unlocked, overflow handling, then a back-to-back burst
        a_locked = 1'b0;
        push_a(8'h11, 1, 4);
        push_a(8'h22, 1, 4);
        push_a(8'h33, 1, 4);
        push_a(8'h44, 1, 4);
        check_eq("fill_full", a_full, 1);
        check_eq("fill_level", a_level, 4);
        check_eq("fill_ovf_clear", a_ovf, 0);
        push_a(8'h55, 0, 4);
        check_eq("ovf_set", a_ovf, 1);
        check_eq("ovf_level", a_level, 4);
        a_ovf_clr = 1'b1;
        @(negedge clk);
        a_ovf_clr = 1'b0;
        check_eq("ovf_cleared", a_ovf, 0);
        a_ovf_clr = 1'b1;
        push_a(8'h66, 0, 4);
        a_ovf_clr = 1'b0;
        check_eq("ovf_set_wins", a_ovf, 1);
        a_ovf_clr = 1'b1;
        @(negedge clk);
        a_ovf_clr = 1'b0;
        check_eq("ovf_cleared2", a_ovf, 0);
        repeat (5) @(negedge clk);
        check_eq("no_start_unlocked", a_busy, 0);
        a_locked = 1'b1;
        wait_busy(1, 10, "burst_go");
        cnt = 0;
        while (a_busy && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        check_eq("burst_busy_len", cnt, 160);
        check_eq("burst_empty", a_empty, 1);

        // Push on the same edge as the pop out of the last stop bit
        push_a(8'h3C, 1, 4);
        repeat (5) @(negedge clk);
        push_a(8'hC3, 1, 4);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (a_done) break;
        end
        check_eq("pp_done_seen", a_done, 1);
        check_eq("pp_level_before", a_level, 1);
        push_a(8'h5A, 1, 4);
        check_eq("pp_level_after", a_level, 1);
        check_eq("pp_b2b_start", a_tx, 0);
        wait_busy(0, 200, "pp_idle");

        // Unlock and change bit period mid-frame
        push_a(8'h96, 1, 4);
        repeat (10) @(negedge clk);
        a_locked = 1'b0;
        a_bp     = 29'd8;
        push_a(8'h69, 1, 8);
        wait_busy(0, 100, "drop_idle");
        repeat (20) @(negedge clk);
        check_eq("held_busy", a_busy, 0);
        check_eq("held_level", a_level, 1);
        a_locked = 1'b1;
        wait_busy(1, 10, "relock_go");
        wait_busy(0, 120, "relock_idle");
        check_eq("sb_drained", sb_a.size(), 0);

        // Asynchronous reset in the middle of a data bit
        mon_en = 1'b0;
        push_a(8'h00, 0, 8);
        push_a(8'hFF, 0, 8);
        repeat (14) @(negedge clk);
        check_eq("pre_reset_tx", a_tx, 0);
        check_eq("pre_reset_level", a_level, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_tx", a_tx, 1);
        check_eq("async_rst_level", a_level, 0);
        check_eq("async_rst_busy", a_busy, 0);
        check_eq("async_rst_empty", a_empty, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_tx", a_tx, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_mismatch);
        $finish;
    end

endmodule
